mem_view_reader: RTL and testbench

- Read-side viewer for the instruction and data memories.
- Steps an address pointer from debounced push-buttons and issues synchronous reads to the selected memory.
- Latches the returned 16-bit word and drives it as 4 hex digits onto the board's multiplexed 7-segment display. The current address is shown on LEDs.
- Sits between the board I/O pins and the read ports of the instruction and data memories.

---
 rtl/mem_view_reader.sv | 278 +++++++++++++++++++++++++++
 tb/tb_mem_view_reader.sv | 273 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_view_reader.sv
// mem_view_reader: steps an address pointer from debounced buttons, fetches
// the selected memory word through a small REQ/WAIT/LATCH sequence and shows
// the latched word as four hex digits on a multiplexed 7-segment display.

// Conditions one raw asynchronous input: two-flop synchronizer followed by a
// debounce counter. chg_o strobes for one cycle when a new level is accepted;
// level_o is the previously accepted level during that strobe.
module mem_view_reader_deb #(
   parameter int DEB_CYCLES = 250000
) (
   input  logic clk_i,
   input  logic rst_i,
   input  logic raw_i,
   output logic level_o,
   output logic chg_o
);
   localparam int CNT_W = (DEB_CYCLES > 1) ? $clog2(DEB_CYCLES + 1) : 1;
   localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEB_CYCLES - 1);

   logic             sync1_q;
   logic             sync2_q;
   logic             lvl_q;
   logic             lvl_d;
   logic [CNT_W-1:0] cnt_q;
   logic [CNT_W-1:0] cnt_d;
   logic             upd_s;

   // Count consecutive samples that disagree with the accepted level.
   always_comb begin
      lvl_d = lvl_q;
      cnt_d = cnt_q;
      upd_s = 1'b0;
      if (sync2_q != lvl_q) begin
         if (cnt_q == CNT_MAX) begin
            upd_s = 1'b1;
            lvl_d = sync2_q;
            cnt_d = '0;
         end else begin
            cnt_d = cnt_q + CNT_W'(1);
         end
      end else begin
         cnt_d = '0;
      end
   end

   // Synchronizer, accepted level and debounce counter registers.
   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         sync1_q <= 1'b0;
         sync2_q <= 1'b0;
         lvl_q   <= 1'b0;
         cnt_q   <= '0;
      end else begin
         sync1_q <= raw_i;
         sync2_q <= sync1_q;
         lvl_q   <= lvl_d;
         cnt_q   <= cnt_d;
      end
   end

   assign level_o = lvl_q;
   assign chg_o   = upd_s;
endmodule

module mem_view_reader #(
   parameter int ADDR_W     = 5,
   parameter int DEB_CYCLES = 250000,
   parameter int REF_BITS   = 18
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              btn_next,
   input  logic              btn_prev,
   input  logic              sw_sel,
   output logic [ADDR_W-1:0] imem_addr,
   input  logic [15:0]       imem_rdata,
   output logic [ADDR_W-1:0] dmem_addr,
   input  logic [15:0]       dmem_rdata,
   output logic [ADDR_W:0]   led,
   output logic [6:0]        seg,
   output logic [3:0]        an
);
   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_REQ   = 2'd1,
      ST_WAIT  = 2'd2,
      ST_LATCH = 2'd3
   } state_t;

   // Active-low {g..a} pattern for one hex digit.
   function automatic logic [6:0] hex7(input logic [3:0] nib);
      logic [6:0] pat;
      case (nib)
         4'h0:    pat = 7'b1000000;
         4'h1:    pat = 7'b1111001;
         4'h2:    pat = 7'b0100100;
         4'h3:    pat = 7'b0110000;
         4'h4:    pat = 7'b0011001;
         4'h5:    pat = 7'b0010010;
         4'h6:    pat = 7'b0000010;
         4'h7:    pat = 7'b1111000;
         4'h8:    pat = 7'b0000000;
         4'h9:    pat = 7'b0010000;
         4'hA:    pat = 7'b0001000;
         4'hB:    pat = 7'b0000011;
         4'hC:    pat = 7'b1000110;
         4'hD:    pat = 7'b0100001;
         4'hE:    pat = 7'b0000110;
         4'hF:    pat = 7'b0001110;
         default: pat = 7'b1111111;
      endcase
      return pat;
   endfunction

   state_t              state_q;
   state_t              state_d;
   logic [ADDR_W-1:0]   addr_q;
   logic [ADDR_W-1:0]   addr_d;
   logic                sel_q;
   logic                sel_d;
   logic [15:0]         shown_q;
   logic [15:0]         shown_d;
   logic [ADDR_W:0]     led_q;
   logic [REF_BITS-1:0] ref_q;
   logic [REF_BITS-1:0] ref_d;
   logic [6:0]          seg_q;
   logic [6:0]          seg_d;
   logic [3:0]          an_q;
   logic [3:0]          an_d;

   logic                next_lvl_s;
   logic                next_chg_s;
   logic                prev_lvl_s;
   logic                prev_chg_s;
   logic                sel_lvl_s;
   logic                sel_chg_s;
   logic                next_pls_s;
   logic                prev_pls_s;
   logic                step_s;
   logic [ADDR_W-1:0]   step_addr_s;
   logic [1:0]          digit_s;
   logic [3:0]          nib_s;

   mem_view_reader_deb #(.DEB_CYCLES(DEB_CYCLES)) u_deb_next (
      .clk_i   (clk),
      .rst_i   (rst),
      .raw_i   (btn_next),
      .level_o (next_lvl_s),
      .chg_o   (next_chg_s)
   );

   mem_view_reader_deb #(.DEB_CYCLES(DEB_CYCLES)) u_deb_prev (
      .clk_i   (clk),
      .rst_i   (rst),
      .raw_i   (btn_prev),
      .level_o (prev_lvl_s),
      .chg_o   (prev_chg_s)
   );

   mem_view_reader_deb #(.DEB_CYCLES(DEB_CYCLES)) u_deb_sel (
      .clk_i   (clk),
      .rst_i   (rst),
      .raw_i   (sw_sel),
      .level_o (sel_lvl_s),
      .chg_o   (sel_chg_s)
   );

   // Press pulses fire only on an accepted 0->1 change; releases are ignored.
   assign next_pls_s = next_chg_s & ~next_lvl_s;
   assign prev_pls_s = prev_chg_s & ~prev_lvl_s;

   // Step decode: simultaneous presses cancel, arithmetic wraps naturally.
   always_comb begin
      step_s      = 1'b0;
      step_addr_s = addr_q;
      if (next_pls_s && !prev_pls_s) begin
         step_s      = 1'b1;
         step_addr_s = addr_q + ADDR_W'(1);
      end else if (prev_pls_s && !next_pls_s) begin
         step_s      = 1'b1;
         step_addr_s = addr_q - ADDR_W'(1);
      end else begin
         step_s      = 1'b0;
         step_addr_s = addr_q;
      end
   end

   // Fetch sequencer: only IDLE accepts steps/select changes, others drop them.
   always_comb begin
      state_d = state_q;
      addr_d  = addr_q;
      sel_d   = sel_q;
      shown_d = shown_q;
      case (state_q)
         ST_IDLE: begin
            if (step_s || sel_chg_s) begin
               addr_d  = step_addr_s;
               state_d = ST_REQ;
               if (sel_chg_s) begin
                  sel_d = ~sel_lvl_s;
               end else begin
                  sel_d = sel_q;
               end
            end else begin
               state_d = ST_IDLE;
            end
         end
         ST_REQ: begin
            state_d = ST_WAIT;
         end
         ST_WAIT: begin
            state_d = ST_LATCH;
         end
         ST_LATCH: begin
            if (sel_q) begin
               shown_d = dmem_rdata;
            end else begin
               shown_d = imem_rdata;
            end
            state_d = ST_IDLE;
         end
         default: begin
            state_d = ST_REQ;
         end
      endcase
   end

   // Fetch sequencer state, pointer, select, shown word and LED registers.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= ST_REQ;
         addr_q  <= '0;
         sel_q   <= 1'b0;
         shown_q <= 16'h0000;
         led_q   <= '0;
      end else begin
         state_q <= state_d;
         addr_q  <= addr_d;
         sel_q   <= sel_d;
         shown_q <= shown_d;
         led_q   <= {sel_d, addr_d};
      end
   end

   // Display scan: pick the digit from the refresh counter's top two bits.
   always_comb begin
      ref_d   = ref_q + REF_BITS'(1);
      digit_s = ref_q[REF_BITS-1 -: 2];
      case (digit_s)
         2'd0:    nib_s = shown_q[3:0];
         2'd1:    nib_s = shown_q[7:4];
         2'd2:    nib_s = shown_q[11:8];
         2'd3:    nib_s = shown_q[15:12];
         default: nib_s = shown_q[3:0];
      endcase
      an_d  = ~(4'b0001 << digit_s);
      seg_d = hex7(nib_s);
   end

   // Refresh counter plus anode/segment registers updated together.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         ref_q <= '0;
         an_q  <= 4'b1110;
         seg_q <= 7'b1000000;
      end else begin
         ref_q <= ref_d;
         an_q  <= an_d;
         seg_q <= seg_d;
      end
   end

   assign imem_addr = addr_q;
   assign dmem_addr = addr_q;
   assign led       = led_q;
   assign seg       = seg_q;
   assign an        = an_q;
endmodule

// File: tb/tb_mem_view_reader.sv
// Directed bench for mem_view_reader: stimulus pushes expected results into a
// queue, a monitor decodes the scanned display and LED outputs and compares.
module tb_mem_view_reader;
   localparam int ADDR_W = 5;
   localparam int DEB    = 4;

   logic              clk = 1'b0;
   logic              rst = 1'b1;
   logic              btn_next = 1'b0;
   logic              btn_prev = 1'b0;
   logic              sw_sel = 1'b0;
   logic [ADDR_W-1:0] imem_addr;
   logic [ADDR_W-1:0] dmem_addr;
   logic [15:0]       imem_rdata = 16'h0000;
   logic [15:0]       dmem_rdata = 16'h0000;
   logic [ADDR_W:0]   led;
   logic [6:0]        seg;
   logic [3:0]        an;

   logic [15:0] imem_mem [0:31];
   logic [15:0] dmem_mem [0:31];

   int checks = 0;
   int errors = 0;

   typedef struct {
      bit          imm;
      string       name;
      logic [5:0]  led;
      logic [4:0]  addr;
      logic [15:0] shown;
   } exp_t;

   exp_t exp_q[$];

   mem_view_reader #(.ADDR_W(ADDR_W), .DEB_CYCLES(DEB), .REF_BITS(4)) dut (
      .clk        (clk),
      .rst        (rst),
      .btn_next   (btn_next),
      .btn_prev   (btn_prev),
      .sw_sel     (sw_sel),
      .imem_addr  (imem_addr),
      .imem_rdata (imem_rdata),
      .dmem_addr  (dmem_addr),
      .dmem_rdata (dmem_rdata),
      .led        (led),
      .seg        (seg),
      .an         (an)
   );

   always #5 clk = ~clk;

   // Synchronous-read memory models.
   always @(posedge clk) begin
      imem_rdata <= imem_mem[imem_addr];
      dmem_rdata <= dmem_mem[dmem_addr];
   end

   function automatic logic [6:0] tb_hex(input logic [3:0] n);
      case (n)
         4'h0: return 7'b1000000;
         4'h1: return 7'b1111001;
         4'h2: return 7'b0100100;
         4'h3: return 7'b0110000;
         4'h4: return 7'b0011001;
         4'h5: return 7'b0010010;
         4'h6: return 7'b0000010;
         4'h7: return 7'b1111000;
         4'h8: return 7'b0000000;
         4'h9: return 7'b0010000;
         4'hA: return 7'b0001000;
         4'hB: return 7'b0000011;
         4'hC: return 7'b1000110;
         4'hD: return 7'b0100001;
         4'hE: return 7'b0000110;
         default: return 7'b0001110;
      endcase
   endfunction

   function automatic logic [3:0] dec_seg(input logic [6:0] s);
      for (int i = 0; i < 16; i++) begin
         if (tb_hex(4'(i)) == s) return 4'(i);
      end
      return 4'bxxxx;
   endfunction

   function automatic int digit_of(input logic [3:0] a);
      case (a)
         4'b1110: return 0;
         4'b1101: return 1;
         4'b1011: return 2;
         4'b0111: return 3;
         default: return -1;
      endcase
   endfunction

   task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s got=%0h exp=%0h", nm, got, exp);
      end
   endtask

   // Monitor: pops one expectation at a time and compares DUT outputs.
   initial begin : monitor
      exp_t        e;
      logic [15:0] got;
      logic [3:0]  seen;
      int          idx;
      forever begin
         @(negedge clk);
         if (exp_q.size() > 0) begin
            e = exp_q[0];
            if (e.imm) begin
               chk({e.name, " an"}, 32'(an), 32'(4'b1110));
               chk({e.name, " seg"}, 32'(seg), 32'(7'b1000000));
               chk({e.name, " led"}, 32'(led), 32'(e.led));
            end else begin
               got  = 16'h0000;
               seen = 4'h0;
               for (int c = 0; c < 20; c++) begin
                  idx = digit_of(an);
                  if (idx >= 0) begin
                     got[idx*4 +: 4] = dec_seg(seg);
                     seen[idx]       = 1'b1;
                  end
                  @(negedge clk);
               end
               chk({e.name, " led"}, 32'(led), 32'(e.led));
               chk({e.name, " imem_addr"}, 32'(imem_addr), 32'(e.addr));
               chk({e.name, " dmem_addr"}, 32'(dmem_addr), 32'(e.addr));
               chk({e.name, " digits_seen"}, 32'(seen), 32'(4'hF));
               chk({e.name, " shown"}, 32'(got), 32'(e.shown));
            end
            void'(exp_q.pop_front());
         end
      end
   end

   task automatic wait_drain(input string nm);
      int n = 0;
      while (exp_q.size() != 0 && n < 300) begin
         @(posedge clk);
         n++;
      end
      if (exp_q.size() != 0) begin
         checks++;
         errors++;
         $display("FAIL %s timeout got=pending exp=drained", nm);
         exp_q.delete();
      end
   endtask

   task automatic expect_disp(input string nm, input logic [5:0] l,
                              input logic [4:0] a, input logic [15:0] s);
      exp_t e;
      e.imm = 1'b0; e.name = nm; e.led = l; e.addr = a; e.shown = s;
      exp_q.push_back(e);
      wait_drain(nm);
   endtask

   task automatic expect_reset(input string nm);
      exp_t e;
      e.imm = 1'b1; e.name = nm; e.led = 6'b000000; e.addr = 5'd0; e.shown = 16'h0000;
      exp_q.push_back(e);
      wait_drain(nm);
   endtask

   task automatic idle(input int n);
      repeat (n) @(negedge clk);
   endtask

   task automatic press(input bit nxt, input bit prv);
      btn_next = nxt;
      btn_prev = prv;
      idle(DEB + 2);
      btn_next = 1'b0;
      btn_prev = 1'b0;
      idle(DEB + 10);
   endtask

   initial begin : stim
      logic [5:0] led_old;
      int         n;
      for (int i = 0; i < 32; i++) begin
         imem_mem[i] = 16'h0000;
         dmem_mem[i] = 16'h0000;
      end
      imem_mem[0]  = 16'h1234;
      imem_mem[1]  = 16'hABCD;
      imem_mem[2]  = 16'h7777;
      imem_mem[31] = 16'h0F0F;
      dmem_mem[1]  = 16'hC0DE;

      // Reset state, then automatic fetch of imem[0].
      idle(2);
      expect_reset("reset");
      rst = 1'b0;
      idle(8);
      expect_disp("boot", 6'b000000, 5'd0, 16'h1234);

      press(1'b1, 1'b0);
      expect_disp("next1", 6'b000001, 5'd1, 16'hABCD);

      // Bouncing button never settles long enough.
      for (int i = 0; i < 10; i++) begin
         btn_next = ~btn_next;
         idle(2);
      end
      btn_next = 1'b0;
      idle(DEB + 10);
      expect_disp("bounce", 6'b000001, 5'd1, 16'hABCD);

      press(1'b0, 1'b1);
      expect_disp("prev0", 6'b000000, 5'd0, 16'h1234);
      press(1'b0, 1'b1);
      expect_disp("wrap_down", 6'b011111, 5'd31, 16'h0F0F);
      press(1'b1, 1'b0);
      expect_disp("wrap_up", 6'b000000, 5'd0, 16'h1234);

      // Switch to data memory.
      imem_mem[0] = 16'h0000;
      dmem_mem[0] = 16'hBEEF;
      sw_sel = 1'b1;
      idle(DEB + 12);
      expect_disp("sel_dmem", 6'b100000, 5'd0, 16'hBEEF);

      press(1'b1, 1'b1);
      expect_disp("both", 6'b100000, 5'd0, 16'hBEEF);

      // prev pulse lands two cycles after next pulse, i.e. during WAIT.
      btn_next = 1'b1;
      idle(2);
      btn_prev = 1'b1;
      idle(4);
      btn_next = 1'b0;
      idle(2);
      btn_prev = 1'b0;
      idle(DEB + 12);
      expect_disp("drop_wait", 6'b100001, 5'd1, 16'hC0DE);

      sw_sel = 1'b0;
      idle(DEB + 12);
      expect_disp("sel_imem", 6'b000001, 5'd1, 16'hABCD);

      // Reset asserted while the fetch of addr 2 is in WAIT.
      imem_mem[0] = 16'h2468;
      led_old  = led;
      btn_next = 1'b1;
      n = 0;
      @(posedge clk);
      #1;
      while (led == led_old && n < 40) begin
         @(posedge clk);
         #1;
         n++;
      end
      chk("mid_led_step", 32'(led), 32'(6'b000010));
      @(posedge clk);
      #1;
      rst      = 1'b1;
      btn_next = 1'b0;
      expect_reset("mid_reset");
      idle(1);
      rst = 1'b0;
      idle(8);
      expect_disp("refetch", 6'b000000, 5'd0, 16'h2468);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
